// File: rtl/code_entry_ctrl.sv
// Key-entry front end for the combinational coded lock.
// Debounces three active-low buttons and shifts a 4-bit code in one bit per press.
// Presents the code with the enable d held high for a fixed verdict window.
// Tracks consecutive wrong codes and applies a timed lockout.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no entry in progress, code=0, waiting for first digit
// ENTRY   | 1..3 digits entered, idle timer running
// PRESENT | 4 digits entered, d=1, verdict sampled on last cycle
// LOCKOUT | too many wrong codes, all key events discarded
module code_entry_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 240000,
  parameter int unsigned TIMEOUT_CYCLES  = 60000000,
  parameter int unsigned PRESENT_CYCLES  = 4,
  parameter int unsigned MAX_FAIL        = 3,
  parameter int unsigned LOCKOUT_CYCLES  = 360000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key0_n,
  input  logic       key1_n,
  input  logic       keyclr_n,
  input  logic       lock_ok,
  input  logic       lock_err,
  output logic       q,
  output logic       u,
  output logic       n,
  output logic       b,
  output logic       d,
  output logic [2:0] digits,
  output logic       unlocked,
  output logic       locked_out
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = $clog2(PRESENT_CYCLES + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ENTRY, PRESENT, LOCKOUT} state_t;

  // Index 0 = key0, 1 = key1, 2 = clear.
  logic [2:0]    raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    level;
  logic [2:0]    evt;
  logic [DW-1:0] db_cnt [3];

  state_t        state;
  logic [3:0]    code;
  logic [FW-1:0] fail_cnt;
  logic [TW-1:0] idle_tmr;
  logic [PW-1:0] pres_tmr;
  logic [LW-1:0] lock_tmr;

  logic dig_ev;
  logic dig_bit;
  logic clr_ev;

  assign raw = {keyclr_n, key1_n, key0_n};

  // Two-flop synchronisers; released (1) is the idle level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 3'b111;
      sync2 <= 3'b111;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: level follows the synchronised key after DEBOUNCE_CYCLES differing
  // samples in a row; a registered pulse marks each accepted press (1->0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 3'b111;
      evt   <= 3'b000;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
          evt[i]    <= 1'b0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          db_cnt[i] <= '0;
          level[i]  <= sync2[i];
          evt[i]    <= ~sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
          evt[i]    <= 1'b0;
        end
      end
    end
  end

  // Clear beats digits; two simultaneous digit keys cancel each other.
  assign clr_ev  = evt[2];
  assign dig_ev  = (evt[0] ^ evt[1]) & ~clr_ev;
  assign dig_bit = evt[1];

  assign q = code[3];
  assign u = code[2];
  assign n = code[1];
  assign b = code[0];

  // Entry / present / lockout sequencing with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      code       <= '0;
      digits     <= '0;
      d          <= 1'b0;
      unlocked   <= 1'b0;
      locked_out <= 1'b0;
      fail_cnt   <= '0;
      idle_tmr   <= '0;
      pres_tmr   <= '0;
      lock_tmr   <= '0;
    end else begin
      unlocked <= 1'b0;
      case (state)
        IDLE: begin
          if (dig_ev) begin
            code     <= {code[2:0], dig_bit};
            digits   <= 3'd1;
            idle_tmr <= TW'(TIMEOUT_CYCLES - 1);
            state    <= ENTRY;
          end
        end
        ENTRY: begin
          if (clr_ev) begin
            code     <= '0;
            digits   <= '0;
            idle_tmr <= '0;
            state    <= IDLE;
          end else if (dig_ev) begin
            code     <= {code[2:0], dig_bit};
            digits   <= digits + 3'd1;
            idle_tmr <= TW'(TIMEOUT_CYCLES - 1);
            if (digits == 3'd3) begin
              d        <= 1'b1;
              pres_tmr <= PW'(PRESENT_CYCLES - 1);
              idle_tmr <= '0;
              state    <= PRESENT;
            end
          end else if (idle_tmr == '0) begin
            code   <= '0;
            digits <= '0;
            state  <= IDLE;
          end else begin
            idle_tmr <= idle_tmr - TW'(1);
          end
        end
        PRESENT: begin
          if (pres_tmr == '0) begin
            d      <= 1'b0;
            code   <= '0;
            digits <= '0;
            if (lock_ok) begin
              unlocked <= 1'b1;
              fail_cnt <= '0;
              state    <= IDLE;
            end else if (fail_cnt >= FW'(MAX_FAIL - 1)) begin
              fail_cnt   <= FW'(MAX_FAIL);
              locked_out <= 1'b1;
              lock_tmr   <= LW'(LOCKOUT_CYCLES - 1);
              state      <= LOCKOUT;
            end else begin
              fail_cnt <= fail_cnt + FW'(1);
              state    <= IDLE;
            end
          end else begin
            pres_tmr <= pres_tmr - PW'(1);
          end
        end
        LOCKOUT: begin
          if (lock_tmr == '0) begin
            locked_out <= 1'b0;
            fail_cnt   <= '0;
            state      <= IDLE;
          end else begin
            lock_tmr <= lock_tmr - LW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_code_entry_ctrl.sv
// Self-checking bench for code_entry_ctrl with small timing parameters.
// A simple lock model answers the verdict; a transaction-level reference model
// predicts digits, code, pulses and lockout from the entered bit sequence.
`timescale 1ns/1ps
module tb_code_entry_ctrl;

  localparam int DEB = 4;
  localparam int TO  = 100;
  localparam int PRS = 4;
  localparam int MF  = 3;
  localparam int LO  = 50;
  localparam logic [3:0] SECRET = 4'b1011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key0_n = 1'b1;
  logic       key1_n = 1'b1;
  logic       keyclr_n = 1'b1;
  logic       lock_ok;
  logic       lock_err;
  logic       q, u, n, b, d, unlocked, locked_out;
  logic [2:0] digits;
  logic [3:0] code_o;

  int verdict_mode = 0;  // 0: real lock, 1: no verdict, 2: both verdicts
  int n_vec = 0;
  int n_err = 0;
  int m_fail = 0;
  int d_cnt = 0, unl_cnt = 0, lo_cnt = 0;

  code_entry_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TO),
    .PRESENT_CYCLES (PRS),
    .MAX_FAIL       (MF),
    .LOCKOUT_CYCLES (LO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key0_n    (key0_n),
    .key1_n    (key1_n),
    .keyclr_n  (keyclr_n),
    .lock_ok   (lock_ok),
    .lock_err  (lock_err),
    .q         (q),
    .u         (u),
    .n         (n),
    .b         (b),
    .d         (d),
    .digits    (digits),
    .unlocked  (unlocked),
    .locked_out(locked_out)
  );

  always #5 clk = ~clk;

  assign code_o   = {q, u, n, b};
  assign lock_ok  = d && (verdict_mode == 2 || (verdict_mode == 0 && code_o == SECRET));
  assign lock_err = d && (verdict_mode == 2 || (verdict_mode == 0 && code_o != SECRET));

  // Cycle counters for d, unlocked and locked_out.
  always @(negedge clk) begin
    if (d) d_cnt++;
    if (unlocked) unl_cnt++;
    if (locked_out) lo_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // which: 0 key0, 1 key1, 2 clear, 3 key0+key1, 4 clear+key1
  task automatic press(input int which);
    @(negedge clk);
    key0_n   = !(which == 0 || which == 3);
    key1_n   = !(which == 1 || which == 3 || which == 4);
    keyclr_n = !(which == 2 || which == 4);
    repeat (DEB + 6 + $urandom_range(0, 3)) @(negedge clk);
    key0_n = 1'b1; key1_n = 1'b1; keyclr_n = 1'b1;
    repeat (DEB + 6 + $urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic enter_partial(input logic [3:0] bits, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      press(int'(bits[3-i]));
      chk("partial_digits", digits, i + 1);
      chk("partial_code", code_o, 32'(bits >> (3 - i)));
    end
  endtask

  task automatic submit(input logic [3:0] bits, input int mode);
    bit ok;
    verdict_mode = mode;
    d_cnt = 0; unl_cnt = 0; lo_cnt = 0;
    enter_partial(bits, 3);
    press(int'(bits[0]));
    ok = (mode == 2) || (mode == 0 && bits == SECRET);
    if (ok) m_fail = 0; else m_fail++;
    chk("d_cycles", d_cnt, PRS);
    chk("unlocked_pulses", unl_cnt, ok);
    chk("digits_after", digits, 0);
    chk("code_after", code_o, 0);
    chk("locked_out", locked_out, m_fail >= MF);
    if (m_fail >= MF) begin
      press(int'($urandom_range(0, 1)));
      chk("lockout_digits", digits, 0);
      chk("lockout_code", code_o, 0);
      for (int k = 0; k < 200 && locked_out; k++) @(negedge clk);
      chk("lockout_end", locked_out, 0);
      chk("lockout_len", lo_cnt, LO);
      m_fail = 0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic abort_clr(input logic [3:0] bits, input int cnt);
    d_cnt = 0;
    enter_partial(bits, cnt);
    press(2);
    chk("clr_digits", digits, 0);
    chk("clr_code", code_o, 0);
    chk("clr_no_d", d_cnt, 0);
  endtask

  task automatic abort_timeout(input logic [3:0] bits, input int cnt);
    d_cnt = 0;
    enter_partial(bits, cnt);
    repeat (60) @(negedge clk);
    chk("to_not_yet", digits, cnt);
    repeat (60) @(negedge clk);
    chk("to_digits", digits, 0);
    chk("to_code", code_o, 0);
    chk("to_no_d", d_cnt, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rc;
    int r, nb;
    bit seen;

    repeat (3) @(negedge clk);
    chk("rst_d", d, 0);
    chk("rst_code", code_o, 0);
    chk("rst_digits", digits, 0);
    chk("rst_unlocked", unlocked, 0);
    chk("rst_locked_out", locked_out, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_digits", digits, 0);

    // Correct code entry.
    submit(SECRET, 0);

    // Bouncing key1 produces a single bit.
    for (int k = 0; k < 10; k++) begin
      key1_n = (k % 2 == 1);
      repeat (2) @(negedge clk);
    end
    key1_n = 1'b0;
    repeat (10) @(negedge clk);
    key1_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("bounce_digits", digits, 1);
    chk("bounce_code", code_o, 1);
    press(2);
    chk("bounce_clr", digits, 0);

    abort_clr(4'b0100, 2);
    abort_timeout(4'b1100, 2);

    // Clear in IDLE does nothing; simultaneous digits cancel; clear beats digit.
    press(2);
    chk("idle_clr", digits, 0);
    press(3);
    chk("both_idle", digits, 0);
    press(1);
    press(3);
    chk("both_entry_digits", digits, 1);
    chk("both_entry_code", code_o, 1);
    press(4);
    chk("clr_key1_digits", digits, 0);
    chk("clr_key1_code", code_o, 0);

    // Lockout after three wrong codes, then normal operation resumes.
    submit(4'b0000, 0);
    submit(4'b1111, 0);
    submit(4'b1010, 0);
    submit(SECRET, 0);

    // Randomised mix of operations.
    for (int it = 0; it < 25; it++) begin
      r = $urandom_range(0, 9);
      rc = 4'($urandom_range(0, 15));
      nb = $urandom_range(1, 3);
      if (r <= 5) begin
        if ($urandom_range(0, 2) == 0) rc = SECRET;
        r = $urandom_range(0, 5);
        submit(rc, (r == 4) ? 1 : (r == 5) ? 2 : 0);
      end else if (r <= 7) begin
        abort_clr(rc, nb);
      end else if (r == 8) begin
        abort_timeout(rc, nb);
      end else begin
        press(3);
        chk("rand_both", digits, 0);
      end
    end

    // Reset during PRESENT clears everything including the failure count.
    while (m_fail < 2) submit(4'b0000, 0);
    verdict_mode = 0;
    unl_cnt = 0;
    enter_partial(SECRET, 3);
    @(negedge clk);
    key1_n = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = d;
    end
    chk("present_seen", seen, 1);
    rst = 1'b1;
    #1;
    chk("rst_present_d", d, 0);
    chk("rst_present_unl", unlocked, 0);
    chk("rst_present_digits", digits, 0);
    chk("rst_present_code", code_o, 0);
    key1_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_present_pulses", unl_cnt, 0);
    rst = 1'b0;
    m_fail = 0;
    repeat (5) @(negedge clk);
    submit(4'b0001, 0);
    submit(4'b0010, 0);
    submit(SECRET, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
